// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and issuer FSM encoding
package alu_pkg;

  localparam int INST_W    = 4;
  localparam int DATA_W    = 16;
  localparam int MAT_BEATS = 8;

  localparam logic [INST_W-1:0] OP_ADD = 4'd0;
  localparam logic [INST_W-1:0] OP_SUB = 4'd1;
  localparam logic [INST_W-1:0] OP_MUL = 4'd2;
  localparam logic [INST_W-1:0] OP_DIV = 4'd3;
  localparam logic [INST_W-1:0] OP_SHL = 4'd4;
  localparam logic [INST_W-1:0] OP_SHR = 4'd5;
  localparam logic [INST_W-1:0] OP_AND = 4'd6;
  localparam logic [INST_W-1:0] OP_OR  = 4'd7;
  localparam logic [INST_W-1:0] OP_XOR = 4'd8;
  localparam logic [INST_W-1:0] OP_MAT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - host command FIFO with registered full/empty flags
module cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_wr, do_rd;

  // A write while full is legal only when the same cycle frees a slot
  assign do_rd = rd_en_i && !empty_q;
  assign do_wr = wr_en_i && (!full_q || do_rd);

  // Next occupancy, so the flags can be registered without a cycle of lag
  always_comb begin
    cnt_d = cnt_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (PW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset; empty_o guards every read
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues buffered commands to the ALU and collects results
module alu_cmd_issuer #(
  parameter int                 INST_W     = alu_pkg::INST_W,
  parameter int                 DATA_W     = alu_pkg::DATA_W,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [INST_W-1:0]  MAT_INST   = alu_pkg::OP_MAT,
  parameter int                 MAT_BEATS  = alu_pkg::MAT_BEATS,
  parameter int                 TIMEOUT    = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [INST_W-1:0] i_cmd_inst,
  input  logic [DATA_W-1:0] i_cmd_a,
  input  logic [DATA_W-1:0] i_cmd_b,
  output logic              o_alu_valid,
  input  logic              i_alu_busy,
  output logic [INST_W-1:0] o_alu_inst,
  output logic [DATA_W-1:0] o_alu_data_a,
  output logic [DATA_W-1:0] o_alu_data_b,
  input  logic              i_alu_out_valid,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_res_valid,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_last,
  output logic              o_err
);

  import alu_pkg::*;

  localparam int CW = INST_W + 2*DATA_W;
  localparam int BW = $clog2(MAT_BEATS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d, exp_q, exp_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              alu_valid_q, alu_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              err_q, err_d;

  logic              push, pop, full, empty, accept, is_mat;
  logic [CW-1:0]     head;
  logic [INST_W-1:0] head_inst;

  assign push      = i_cmd_valid && o_cmd_ready;
  assign accept    = alu_valid_q && !i_alu_busy;
  assign head_inst = head[CW-1 -: INST_W];
  assign is_mat    = (exp_q == BW'(MAT_BEATS));

  cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .wr_en_i   (push),
    .wr_data_i ({i_cmd_inst, i_cmd_a, i_cmd_b}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Command sequencing, beat issue, result forwarding and watchdog
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    exp_d       = exp_q;
    wd_d        = wd_q;
    alu_valid_d = alu_valid_q;
    inst_d      = inst_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = 1'b0;
    res_last_d  = 1'b0;
    res_data_d  = res_data_q;
    err_d       = err_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        alu_valid_d = 1'b0;
        if (!empty) begin
          state_d = ST_ISSUE;
          beat_d  = '0;
          exp_d   = (head_inst == MAT_INST) ? BW'(MAT_BEATS) : BW'(1);
          alu_valid_d = !i_alu_busy;
          {inst_d, a_d, b_d} = head;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          // The bus always mirrors the FIFO head, so the accepted entry is the one popped
          pop         = 1'b1;
          beat_d      = beat_q + 1'b1;
          alu_valid_d = 1'b0;
          if (!is_mat || beat_d == BW'(MAT_BEATS)) begin
            state_d = ST_WAIT;
            wd_d    = '0;
          end
        end else if (!alu_valid_q && !empty) begin
          if (is_mat && beat_q != '0 && head_inst != MAT_INST) begin
            // A scalar slipped into a matrix load: drop it and flag the violation
            pop   = 1'b1;
            err_d = 1'b1;
          end else begin
            alu_valid_d = !i_alu_busy;
            {inst_d, a_d, b_d} = head;
          end
        end
      end
      ST_WAIT: begin
        alu_valid_d = 1'b0;
        if (i_alu_out_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = i_alu_data;
          exp_d       = exp_q - 1'b1;
          wd_d        = '0;
          if (exp_q == BW'(1)) begin
            res_last_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_d == WW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      exp_q       <= '0;
      wd_q        <= '0;
      alu_valid_q <= 1'b0;
      inst_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      exp_q       <= exp_d;
      wd_q        <= wd_d;
      alu_valid_q <= alu_valid_d;
      inst_q      <= inst_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign o_cmd_ready  = !full;
  assign o_alu_valid  = alu_valid_q;
  assign o_alu_inst   = inst_q;
  assign o_alu_data_a = a_q;
  assign o_alu_data_b = b_q;
  assign o_res_valid  = res_valid_q;
  assign o_res_data   = res_data_q;
  assign o_res_last   = res_last_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer with a behavioural ALU
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_inst;
  logic [15:0] cmd_a, cmd_b;
  logic        alu_valid, alu_busy;
  logic [3:0]  alu_inst;
  logic [15:0] alu_a, alu_b;
  logic        alu_out_valid;
  logic [15:0] alu_data;
  logic        res_valid, res_last, err;
  logic [15:0] res_data;

  alu_cmd_issuer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_inst(cmd_inst), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
    .o_alu_valid(alu_valid), .i_alu_busy(alu_busy),
    .o_alu_inst(alu_inst), .o_alu_data_a(alu_a), .o_alu_data_b(alu_b),
    .i_alu_out_valid(alu_out_valid), .i_alu_data(alu_data),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_res_last(res_last),
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          acc_cnt = 0;
  logic [35:0] exp_beat[$];
  logic [16:0] exp_res[$];
  bit          mdl_silent = 0;
  logic [15:0] mdl_q[$];
  int          mdl_beats = 0;
  bit          mdl_go = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: compares every accepted ALU beat and every host result against the queues
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (alu_valid && !alu_busy) begin
        acc_cnt++;
        if (exp_beat.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL unexpected_beat: got %0h required none", {alu_inst, alu_a, alu_b});
        end else chk("alu_beat", {alu_inst, alu_a, alu_b}, exp_beat.pop_front());
      end
      if (res_valid) begin
        if (exp_res.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL unexpected_result: got %0h required none", {res_last, res_data});
        end else chk("result", 36'({res_last, res_data}), 36'(exp_res.pop_front()));
      end
    end
  end

  // Behavioural ALU: result = a + b per beat, released after a full command
  initial begin
    alu_out_valid = 1'b0;
    alu_data      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_q.delete(); mdl_beats = 0; mdl_go = 0;
      end else if (alu_valid && !alu_busy) begin
        if (!mdl_silent) mdl_q.push_back(16'(alu_a + alu_b));
        mdl_beats++;
        if (alu_inst != OP_MAT || mdl_beats == MAT_BEATS) begin
          mdl_beats = 0; mdl_go = 1;
        end
      end
      @(posedge clk); #1;
      if (mdl_go && mdl_q.size() > 0) begin
        alu_out_valid = 1'b1; alu_data = mdl_q.pop_front();
      end else begin
        alu_out_valid = 1'b0;
        if (mdl_q.size() == 0) mdl_go = 0;
      end
    end
  end

  task automatic wait_push();
    int  t = 0;
    logic rdy;
    forever begin
      @(negedge clk); rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) break;
      if (++t > 300) begin
        n_cmp++; n_mis++;
        $display("FAIL push_timeout: got ready=0 required ready=1");
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] inst, input logic [15:0] a, input logic [15:0] b);
    cmd_valid = 1'b1; cmd_inst = inst; cmd_a = a; cmd_b = b;
    exp_beat.push_back({inst, a, b});
    wait_push();
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_beat.size() != 0 || exp_res.size() != 0) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    chk({name, "_drain"}, 36'(exp_beat.size() + exp_res.size()), 36'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "global timeout");
  end

  logic [15:0] mat_res [8] = '{16'h0011, 16'h0012, 16'h0013, 16'h0014,
                               16'h0015, 16'h0016, 16'h0017, 16'h0018};
  logic [15:0] ff_res  [5] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};

  initial begin
    int base, hi, n, t;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_inst = '0; cmd_a = '0; cmd_b = '0; alu_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 36'(cmd_ready), 36'(1));
    chk("rst_alu_valid", 36'(alu_valid), 36'(0));
    chk("rst_alu_bus",   {alu_inst, alu_a, alu_b}, 36'(0));
    chk("rst_res",       36'({res_valid, res_last, res_data}), 36'(0));
    chk("rst_err",       36'(err), 36'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD 1.0 + 2.0 = 3.0 in 6Q10
    exp_res.push_back({1'b1, 16'h0C00});
    push(OP_ADD, 16'h0400, 16'h0800);
    drain("add");
    chk("add_err", 36'(err), 36'(0));

    // Busy backpressure
    base = acc_cnt; alu_busy = 1'b1;
    exp_res.push_back({1'b1, 16'h0300});
    push(OP_ADD, 16'h0100, 16'h0200);
    hi = 0;
    repeat (5) begin
      @(negedge clk); if (alu_valid) hi++;
      @(posedge clk); #1;
    end
    chk("busy_valid_low", 36'(hi), 36'(0));
    alu_busy = 1'b0;
    drain("busy");
    chk("busy_one_beat", 36'(acc_cnt - base), 36'(1));

    // Matrix: 8 beats in order, 8 results, last only on the 8th
    base = acc_cnt;
    for (int i = 0; i < 8; i++) exp_res.push_back({i == 7, mat_res[i]});
    for (int i = 0; i < 8; i++) push(OP_MAT, 16'(i + 1), 16'h0010);
    drain("mat");
    chk("mat_beats", 36'(acc_cnt - base), 36'(8));
    chk("mat_err", 36'(err), 36'(0));

    // FIFO full with the ALU stalled
    alu_busy = 1'b1;
    for (int i = 0; i < 5; i++) exp_res.push_back({1'b1, ff_res[i]});
    for (int i = 0; i < 4; i++) push(OP_ADD, 16'(16'h0100 * (i + 1)), 16'(i + 1));
    @(negedge clk);
    chk("full_ready_low", 36'(cmd_ready), 36'(0));
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_inst = OP_ADD; cmd_a = 16'h0500; cmd_b = 16'h0005;
    exp_beat.push_back({OP_ADD, 16'h0500, 16'h0005});
    hi = 0;
    repeat (3) begin
      @(negedge clk); if (cmd_ready) hi++;
      @(posedge clk); #1;
    end
    chk("full_5th_held", 36'(hi), 36'(0));
    alu_busy = 1'b0;
    wait_push();
    drain("full");

    // Timeout: ALU never answers
    mdl_silent = 1;
    push(OP_ADD, 16'h0001, 16'h0001);
    t = 0;
    do begin @(negedge clk); t++; end while (!(alu_valid && !alu_busy) && t < 100);
    @(negedge clk);
    n = 0;
    while (!err && n < 200) begin @(negedge clk); n++; end
    chk("timeout_cycles", 36'(n), 36'(64));
    @(posedge clk); #1;
    mdl_silent = 0;
    exp_res.push_back({1'b1, 16'h0003});
    push(OP_ADD, 16'h0001, 16'h0002);
    drain("post_timeout");
    chk("err_sticky", 36'(err), 36'(1));

    // Reset in the middle of a matrix load
    base = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      if (acc_cnt - base >= 3) break;
      push(OP_MAT, 16'(i + 1), 16'h0000);
    end
    t = 0;
    while (acc_cnt - base < 3 && t < 100) begin @(posedge clk); #1; t++; end
    chk("mid_mat_beats", 36'(acc_cnt - base), 36'(3));
    rst_n = 1'b0;
    #1;
    exp_beat.delete(); exp_res.delete();
    chk("mrst_cmd_ready", 36'(cmd_ready), 36'(1));
    chk("mrst_alu_valid", 36'(alu_valid), 36'(0));
    chk("mrst_alu_bus",   {alu_inst, alu_a, alu_b}, 36'(0));
    chk("mrst_res",       36'({res_valid, res_last, res_data}), 36'(0));
    chk("mrst_err",       36'(err), 36'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hi = 0;
    repeat (10) begin
      @(negedge clk); if (alu_valid) hi++;
      @(posedge clk); #1;
    end
    chk("mrst_fifo_empty", 36'(hi), 36'(0));
    exp_res.push_back({1'b1, 16'h8000});
    push(OP_ADD, 16'h7FFF, 16'h0001);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
